// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard sequencer for a classic 5-stage pipeline.
// Generates per-stage register enables, the ID/EX bubble and the younger-stage
// flushes for load-use stalls, taken branches resolved in MEM and multi-cycle
// data-memory accesses (with a timeout). Keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err,
    output logic [1:0]       state
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              flush_event;
    logic              luh;

    // x0 is hardwired, so a load targeting it can never create a dependency.
    assign luh = ex_memread && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    // Stage controls and next-state: memory freeze beats branch beats load-use.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        flush_event  = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;

        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ack) begin
                    // Freeze every stage; the first waiting cycle is this one.
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (mem_branch_taken) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    {if_id_flush, id_ex_flush, ex_mem_flush}          = 3'b111;
                    flush_event = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (luh) begin
                    // Hold PC and IF/ID one cycle while the load moves into MEM.
                    {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                    id_ex_bubble = 1'b1;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Give up on the access so the pipe cannot hang forever.
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    mem_err_d  = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_FLUSH: begin
                // Younger stages hold NOPs, so hazards seen now are not real.
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!arst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            id_ex_bubble = 1'b0;
            {if_id_flush, id_ex_flush, ex_mem_flush}          = 3'b000;
            flush_event  = 1'b0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_event && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, wait timer, counters and sticky error register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    localparam logic [8:0] EV_FREEZE = 9'b00000_0_000;
    localparam logic [8:0] EV_RUN    = 9'b11111_0_000;
    localparam logic [8:0] EV_STALL  = 9'b00111_1_000;
    localparam logic [8:0] EV_BRANCH = 9'b11111_0_111;

    logic clk = 1'b0;
    logic arst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_memread, mem_branch_taken, dmem_req, dmem_ack;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_err;
    logic [1:0] state;
    logic [8:0] ev;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_err(mem_err), .state(state)
    );

    assign ev = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0;
        mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic set_luh();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    endtask

    // Behavioural model: mode 0=running, 1=waiting on memory, 2=flush shadow.
    int m_mode   = 0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_flush  = 0;
    bit m_err    = 1'b0;
    bit m_valid  = 1'b0;

    always @(negedge clk) begin : model
        logic [8:0] e;
        bit hazard;
        int nmode;
        hazard = ex_memread && (ex_rd != 0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        e = EV_FREEZE;
        nmode = m_mode;
        if (m_valid) begin
            chk("state", 32'(state), 32'(m_mode));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
            chk("mem_err", 32'(mem_err), 32'(m_err));
        end
        if (!arst_n) begin
            e = EV_FREEZE;
        end else if (m_mode == 0) begin
            if (dmem_req && !dmem_ack) begin
                e = EV_FREEZE; nmode = 1; m_waited = 1;
            end else if (mem_branch_taken) begin
                e = EV_BRANCH; nmode = 2;
                m_flush = (m_flush < CNT_SAT) ? m_flush + 1 : CNT_SAT;
            end else if (hazard) begin
                e = EV_STALL;
            end else begin
                e = EV_RUN;
            end
        end else if (m_mode == 1) begin
            if (dmem_ack) begin
                e = EV_RUN; nmode = 0;
            end else if (m_waited + 1 == MAX_WAIT) begin
                e = EV_RUN; nmode = 0; m_err = 1'b1;
            end else begin
                e = EV_FREEZE; m_waited++;
            end
        end else begin
            e = EV_RUN; nmode = 0;
        end
        if (m_valid) chk("stage_ctl", 32'(ev), 32'(e));
        if (arst_n && !e[8]) m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : CNT_SAT;
        m_mode = nmode;
        if (!arst_n) begin
            m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
            m_valid = 1'b1;
        end
    end

    initial begin
        arst_n = 1'b0;
        clr();
        // Reset
        step(); step(); #2;
        chk("rst_ctl", 32'(ev), 32'(EV_FREEZE));
        chk("rst_state", 32'(state), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        chk("rst_err", 32'(mem_err), 0);
        // Load-use
        step(); arst_n = 1'b1; set_luh(); #2;
        chk("lu_stall", 32'(ev), 32'(EV_STALL));
        step(); clr(); #2;
        chk("lu_release", 32'(ev), 32'(EV_RUN));
        chk("lu_cnt", 32'(stall_cnt), 1);
        // rs2 gating and x0
        step(); ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd1; #2;
        chk("rs2_unused", 32'(ev), 32'(EV_RUN));
        step(); id_uses_rs2 = 1'b1; #2;
        chk("rs2_used", 32'(ev), 32'(EV_STALL));
        step(); clr(); ex_memread = 1'b1; #2;
        chk("x0_nostall", 32'(ev), 32'(EV_RUN));
        chk("rs2_cnt", 32'(stall_cnt), 2);
        // Branch flush, hazard masked during the flush cycle
        step(); clr(); mem_branch_taken = 1'b1; #2;
        chk("br_flush", 32'(ev), 32'(EV_BRANCH));
        step(); clr(); set_luh(); #2;
        chk("fl_state", 32'(state), 2);
        chk("fl_mask", 32'(ev), 32'(EV_RUN));
        chk("fl_cnt", 32'(flush_cnt), 1);
        step(); clr(); #2;
        chk("fl_done", 32'(state), 0);
        // Memory wait with hazard present: freeze only, ack after 3 frozen cycles
        step(); dmem_req = 1'b1; set_luh(); #2;
        chk("mw_prio", 32'(ev), 32'(EV_FREEZE));
        step(); clr(); dmem_req = 1'b1; #2;
        chk("mw_frz2", 32'(ev), 32'(EV_FREEZE));
        chk("mw_state", 32'(state), 1);
        step(); #2;
        chk("mw_frz3", 32'(ev), 32'(EV_FREEZE));
        step(); dmem_ack = 1'b1; #2;
        chk("mw_ack", 32'(ev), 32'(EV_RUN));
        step(); clr(); #2;
        chk("mw_run", 32'(state), 0);
        chk("mw_cnt", 32'(stall_cnt), 5);
        chk("mw_noerr", 32'(mem_err), 0);
        // Timeout: three frozen cycles, release on the fourth
        step(); dmem_req = 1'b1; #2;
        chk("to_frz1", 32'(ev), 32'(EV_FREEZE));
        step(); #2;
        chk("to_frz2", 32'(ev), 32'(EV_FREEZE));
        step(); #2;
        chk("to_frz3", 32'(ev), 32'(EV_FREEZE));
        step(); #2;
        chk("to_release", 32'(ev), 32'(EV_RUN));
        step(); clr(); #2;
        chk("to_state", 32'(state), 0);
        chk("to_err", 32'(mem_err), 1);
        chk("to_cnt", 32'(stall_cnt), 8);
        step(); #2;
        chk("to_sticky", 32'(mem_err), 1);
        // Reset in the middle of a wait
        step(); dmem_req = 1'b1;
        step(); #2;
        chk("rw_state", 32'(state), 1);
        arst_n = 1'b0; #1;
        chk("rw_ctl", 32'(ev), 32'(EV_FREEZE));
        step(); #2;
        chk("rw_state0", 32'(state), 0);
        chk("rw_stall", 32'(stall_cnt), 0);
        chk("rw_flush", 32'(flush_cnt), 0);
        chk("rw_err", 32'(mem_err), 0);
        step(); arst_n = 1'b1; clr();
        // Randomized traffic; ack likelihood varies by phase to hit timeouts
        for (int i = 0; i < 4000; i++) begin
            int ack_pct;
            step();
            ack_pct = ((i / 500) % 3 == 0) ? 40 : (((i / 500) % 3 == 1) ? 10 : 0);
            arst_n           = ($urandom_range(0, 399) != 0);
            ex_memread       = ($urandom_range(0, 2) == 0);
            ex_rd            = 5'($urandom_range(0, 3));
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            id_uses_rs2      = ($urandom_range(0, 1) == 1);
            mem_branch_taken = ($urandom_range(0, 7) == 0);
            dmem_req         = ($urandom_range(0, 5) == 0);
            dmem_ack         = ($urandom_range(0, 99) < ack_pct);
        end
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
